map_ram_reader: RTL and testbench

- Read-side counterpart of the map RAM update path.
- Scans the tile map RAM row by row through its read port and emits one 4-bit cell code per handshake, in raster order (x fastest).
- Feeds the tile renderer / VGA sprite lookup so drawing never indexes the 160-bit rows directly.
- Reads are non-destructive; the block never writes the RAM.

---
 rtl/map_ram_reader.sv | 153 +++++++++++++++
 tb/tb_map_ram_reader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_ram_reader.sv
// ============================================================================
// Module      : map_ram_reader
// Description : Raster-order reader for the tile map RAM. Fetches one row at a
//               time through the RAM read port and streams its cell codes over
//               a valid/ready handshake. Optional macro MAP_READER_PREFETCH_EN
//               adds a shadow row buffer so consecutive rows stream back to back.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module map_ram_reader #(
  parameter int COLS   = 40,
  parameter int ROWS   = 30,
  parameter int CELL_W = 4,
  parameter int DATA_W = COLS * CELL_W
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  output logic [4:0]        rdaddr,
  input  logic [DATA_W-1:0] rddata,
  output logic              tile_valid,
  input  logic              tile_ready,
  output logic [CELL_W-1:0] tile_code,
  output logic [5:0]        tile_x,
  output logic [4:0]        tile_y,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_LATCH  = 2'd2,
    S_STREAM = 2'd3
  } state_t;

  localparam logic [5:0] c_LAST_COL = 6'(COLS - 1);
  localparam logic [4:0] c_LAST_ROW = 5'(ROWS - 1);

  state_t            r_state;
  logic [DATA_W-1:0] r_buf;

  logic       w_accept;
  logic       w_last_col;
  logic       w_last_row;
  logic [4:0] w_row_inc;

  assign w_accept   = tile_valid & tile_ready;
  assign w_last_col = (tile_x == c_LAST_COL);
  assign w_last_row = (tile_y == c_LAST_ROW);
  assign w_row_inc  = tile_y + 5'd1;
  // Cell 0 lives in the MSBs, so the head of the shift register is the current cell.
  assign tile_code  = r_buf[DATA_W-1 -: CELL_W];

`ifdef MAP_READER_PREFETCH_EN
  logic [DATA_W-1:0] r_shadow;
  logic [1:0]        r_pf_step;
  logic [4:0]        w_row_inc2;

  assign w_row_inc2 = tile_y + 5'd2;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_buf      <= '0;
      rdaddr     <= '0;
      tile_valid <= 1'b0;
      tile_x     <= '0;
      tile_y     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef MAP_READER_PREFETCH_EN
      r_shadow   <= '0;
      r_pf_step  <= 2'd0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A start coinciding with the done pulse belongs to the finished frame.
          if (start && !frame_done) begin
            r_state <= S_FETCH;
            busy    <= 1'b1;
            rdaddr  <= '0;
            tile_x  <= '0;
            tile_y  <= '0;
          end
        end

        S_FETCH: begin
          r_state <= S_LATCH;
        end

        S_LATCH: begin
          r_buf      <= rddata;
          tile_x     <= '0;
          tile_valid <= 1'b1;
          r_state    <= S_STREAM;
`ifdef MAP_READER_PREFETCH_EN
          if (!w_last_row) begin
            rdaddr    <= w_row_inc;
            r_pf_step <= 2'd2;
          end
`endif
        end

        S_STREAM: begin
`ifdef MAP_READER_PREFETCH_EN
          // Step 2: RAM clocks the address in; step 1: its data is on rddata.
          if (r_pf_step == 2'd2) begin
            r_pf_step <= 2'd1;
          end else if (r_pf_step == 2'd1) begin
            r_shadow  <= rddata;
            r_pf_step <= 2'd0;
          end
`endif
          if (w_accept) begin
            if (!w_last_col) begin
              tile_x <= tile_x + 6'd1;
              r_buf  <= {r_buf[DATA_W-CELL_W-1:0], {CELL_W{1'b0}}};
            end else if (!w_last_row) begin
              tile_x <= '0;
              tile_y <= w_row_inc;
`ifdef MAP_READER_PREFETCH_EN
              r_buf  <= r_shadow;
              if (w_row_inc != c_LAST_ROW) begin
                rdaddr    <= w_row_inc2;
                r_pf_step <= 2'd2;
              end
`else
              rdaddr     <= w_row_inc;
              tile_valid <= 1'b0;
              r_state    <= S_FETCH;
`endif
            end else begin
              tile_valid <= 1'b0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              r_state    <= S_IDLE;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_map_ram_reader.sv
// Scoreboard bench for map_ram_reader: directed frames with a behavioural
// synchronous-read RAM; accepted tiles are popped from an expected queue.
`default_nettype none

module tb_map_ram_reader;

  localparam int COLS   = 40;
  localparam int ROWS   = 30;
  localparam int CELL_W = 4;
  localparam int DATA_W = COLS * CELL_W;
`ifdef MAP_READER_PREFETCH_EN
  localparam int EXP_CYC = 1202;
  localparam int EXP_BUB = 2;
`else
  localparam int EXP_CYC = 1200 + 2 + 29 * 2;
  localparam int EXP_BUB = 2 + 29 * 2;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [4:0]        rdaddr;
  logic [DATA_W-1:0] rddata;
  logic              tile_valid;
  logic              tile_ready = 1'b0;
  logic [CELL_W-1:0] tile_code;
  logic [5:0]        tile_x;
  logic [4:0]        tile_y;
  logic              busy;
  logic              frame_done;

  map_ram_reader #(.COLS(COLS), .ROWS(ROWS), .CELL_W(CELL_W), .DATA_W(DATA_W)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .start      (start),
    .rdaddr     (rdaddr),
    .rddata     (rddata),
    .tile_valid (tile_valid),
    .tile_ready (tile_ready),
    .tile_code  (tile_code),
    .tile_x     (tile_x),
    .tile_y     (tile_y),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [32];
  logic [3:0]        cells [32][40];
  int                cyc = 0;

  always @(posedge clk) begin
    rddata <= mem[rdaddr];
    cyc    <= cyc + 1;
  end

  int          checks = 0;
  int          errors = 0;
  int          fd_cnt = 0;
  int          bubbles = 0;
  logic [14:0] exp_q [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // Monitor: pops one expected tile per accepted handshake.
  task automatic run_monitor();
    logic [14:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (busy && !tile_valid) bubbles++;
        if (frame_done) fd_cnt++;
        if (tile_valid && tile_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL tile_unexpected: got code=%0d x=%0d y=%0d, none expected",
                     tile_code, tile_x, tile_y);
          end else begin
            e = exp_q.pop_front();
            if ({tile_code, tile_x, tile_y} !== e) begin
              errors++;
              $display("FAIL tile: got code=%0d x=%0d y=%0d expected code=%0d x=%0d y=%0d",
                       tile_code, tile_x, tile_y, e[14:11], e[10:5], e[4:0]);
            end
          end
        end
      end
    end
  endtask

  task automatic pack_rows();
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < COLS; x++)
        mem[y][DATA_W-1-CELL_W*x -: CELL_W] = cells[y][x];
  endtask

  task automatic push_frame();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        exp_q.push_back({cells[y][x], 6'(x), 5'(y)});
  endtask

  task automatic pattern_sparse();
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < COLS; x++)
        cells[y][x] = 4'd0;
    cells[0][0]   = 4'd4;
    cells[0][39]  = 4'd1;
    cells[29][39] = 4'd15;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20 && !tile_valid; i++) step();
    if (!tile_valid) timeout(name);
  endtask

  task automatic wait_done(input string name, output int at);
    at = -1;
    for (int i = 0; i < 5000; i++) begin
      step();
      if (frame_done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) timeout(name);
  endtask

  initial begin
    int n0, at, fd0, b0;
    bit hit;
    fork
      run_monitor();
    join_none

    // Reset and idle
    pattern_sparse();
    pack_rows();
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("idle_valid", int'(tile_valid), 0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(frame_done), 0);
      chk("idle_rdaddr", int'(rdaddr), 0);
      step();
    end

    // Frame 1: sparse pattern, always ready
    push_frame();
    tile_ready = 1'b1;
    fd0 = fd_cnt;
    b0 = bubbles;
    start = 1'b1;
    n0 = cyc + 1;
    step();
    start = 1'b0;
    chk("f1_busy_rise", int'(busy), 1);
    chk("f1_valid_lat1", int'(tile_valid), 0);
    step();
    chk("f1_valid_lat2", int'(tile_valid), 0);
    step();
    chk("f1_valid_lat3", int'(tile_valid), 1);
    chk("f1_first_code", int'(tile_code), 4);
    wait_done("f1_done", at);
    if (at >= 0) begin
      chk("f1_cycles", at - n0, EXP_CYC);
      chk("f1_busy_fall", int'(busy), 0);
    end
    step();
    chk("f1_done_pulse", int'(frame_done), 0);
    chk("f1_done_count", fd_cnt - fd0, 1);
    chk("f1_bubbles", bubbles - b0, EXP_BUB);
    chk("f1_drained", exp_q.size(), 0);

    // Frame 2: dense pattern, stall at (3,0), start while busy, start at done
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < COLS; x++)
        cells[y][x] = 4'((x * 7 + y * 3 + 1) & 15);
    pack_rows();
    push_frame();
    fd0 = fd_cnt;
    tile_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid("f2_first_valid");
    tile_ready = 1'b1;
    step();
    step();
    step();
    tile_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_x", int'(tile_x), 3);
      chk("stall_y", int'(tile_y), 0);
      chk("stall_code", int'(tile_code), int'(cells[0][3]));
      step();
    end
    tile_ready = 1'b1;
    step();
    chk("stall_next_x", int'(tile_x), 4);
    hit = 1'b0;
    at = -1;
    for (int i = 0; i < 5000; i++) begin
      tile_ready = ((cyc % 3) != 2);
      start = 1'b0;
      if (!hit && tile_valid && tile_y == 5'd2 && tile_x == 6'd10) begin
        start = 1'b1;
        hit = 1'b1;
      end
      step();
      if (frame_done) begin
        at = cyc;
        break;
      end
    end
    start = 1'b0;
    if (at < 0) timeout("f2_done");
    chk("f2_start_pulsed", int'(hit), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_at_done_ignored", int'(busy), 0);
    for (int i = 0; i < 10; i++) step();
    chk("f2_stays_idle", int'(busy), 0);
    chk("f2_done_count", fd_cnt - fd0, 1);
    chk("f2_drained", exp_q.size(), 0);

    // Reset during the row-7 latch
    tile_ready = 1'b1;
    pattern_sparse();
    pack_rows();
    push_frame();
    fd0 = fd_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (tile_valid && tile_x == 6'd39 && tile_y == 5'd6) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    if (!hit) timeout("row6_end");
    step();
`ifndef MAP_READER_PREFETCH_EN
    chk("fetch_rdaddr", int'(rdaddr), 7);
    chk("fetch_valid", int'(tile_valid), 0);
    step();
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    chk("rst_valid", int'(tile_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rdaddr", int'(rdaddr), 0);
    chk("rst_x", int'(tile_x), 0);
    chk("rst_y", int'(tile_y), 0);
    chk("rst_code", int'(tile_code), 0);
    step();
    chk("rst_no_done", fd_cnt - fd0, 0);

    // Frame 3: rescan after reset; RAM writes while row 0 streams
    cells[1][5] = 4'd9;
    push_frame();
    fd0 = fd_cnt;
    b0 = bubbles;
    start = 1'b1;
    n0 = cyc + 1;
    step();
    start = 1'b0;
    wait_valid("f3_first_valid");
    chk("f3_first_x", int'(tile_x), 0);
    chk("f3_first_y", int'(tile_y), 0);
    mem[1][DATA_W-1-CELL_W*5 -: CELL_W]  = 4'd9;
    mem[0][DATA_W-1-CELL_W*20 -: CELL_W] = 4'd7;
    wait_done("f3_done", at);
    if (at >= 0) chk("f3_cycles", at - n0, EXP_CYC);
    step();
    chk("f3_done_count", fd_cnt - fd0, 1);
    chk("f3_bubbles", bubbles - b0, EXP_BUB);
    chk("f3_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
